// File: rtl/rv_banco_registros_if.sv
// Register file access bundle: two read address/data pairs plus one write port.
// Latency: reads are combinational, writes commit on the rising clock edge.
// Backpressure: none; every request is accepted every cycle.
interface rv_banco_registros_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] read_reg1;
   logic [ADDR_WIDTH-1:0] read_reg2;
   logic [ADDR_WIDTH-1:0] write_reg;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  RegWrite;
   logic [DATA_WIDTH-1:0] read_data1;
   logic [DATA_WIDTH-1:0] read_data2;

   // Datapath side: issues indices and writeback data, consumes operands.
   modport master (
      output read_reg1, read_reg2, write_reg, write_data, RegWrite,
      input  read_data1, read_data2
   );

   // Register file side.
   modport slave (
      input  read_reg1, read_reg2, write_reg, write_data, RegWrite,
      output read_data1, read_data2
   );
endinterface

// File: rtl/rv_banco_registros.sv
// RV32I integer register file: 32 x DATA_WIDTH, x0 reads as zero, two read ports, one write port.
// Latency: reads zero-cycle combinational; a write is visible right after the edge that commits it.
// Backpressure: none; no bypass, so a same-cycle read of the written index returns the old value.
module rv_banco_registros #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic                clk,
   input logic                rsta,
   rv_banco_registros_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];

   // Storage: async clear dominates any coincident edge; writes to x0 are dropped.
   always_ff @(posedge clk or posedge rsta) begin
      if (rsta) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.RegWrite && (bus.write_reg != '0)) begin
         regs[bus.write_reg] <= bus.write_data;
      end
   end

   // Read ports: index 0 is forced to zero rather than trusting regs[0].
   always_comb begin
      bus.read_data1 = '0;
      bus.read_data2 = '0;
      if (bus.read_reg1 != '0) begin
         bus.read_data1 = regs[bus.read_reg1];
      end
      if (bus.read_reg2 != '0) begin
         bus.read_data2 = regs[bus.read_reg2];
      end
   end

endmodule

// File: tb/tb_rv_banco_registros.sv
// Testbench for rv_banco_registros: directed vectors, expected values queued by stimulus.
// A monitor pops and compares on the falling edge whenever a read is flagged for checking.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_rv_banco_registros;

   localparam int DW = 32;
   localparam int AW = 5;

   logic clk;
   logic rsta;
   logic chk_vld;

   int tests;
   int fails;

   string           q_name [$];
   logic [DW-1:0]   q_exp1 [$];
   logic [DW-1:0]   q_exp2 [$];

   rv_banco_registros_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

   rv_banco_registros #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk  (clk),
      .rsta (rsta),
      .bus  (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: never let the run hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "timeout");
   end

   // Monitor: compares both read ports against the oldest queued expectation.
   initial begin
      string         nm;
      logic [DW-1:0] e1;
      logic [DW-1:0] e2;
      forever begin
         @(negedge clk);
         if (chk_vld) begin
            if (q_name.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL scoreboard_empty: got check request, required queued expectation");
            end else begin
               nm = q_name.pop_front();
               e1 = q_exp1.pop_front();
               e2 = q_exp2.pop_front();
               tests++;
               if (bus_if.read_data1 !== e1) begin
                  fails++;
                  $display("FAIL %s port1: got %h required %h", nm, bus_if.read_data1, e1);
               end
               tests++;
               if (bus_if.read_data2 !== e2) begin
                  fails++;
                  $display("FAIL %s port2: got %h required %h", nm, bus_if.read_data2, e2);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present read indices, queue the expected data, flag one falling-edge sample,
   // then advance past the next rising edge (which commits any pending write).
   task automatic expect_rd(input string nm, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                            input logic [DW-1:0] e1, input logic [DW-1:0] e2);
      bus_if.read_reg1 = r1;
      bus_if.read_reg2 = r2;
      q_name.push_back(nm);
      q_exp1.push_back(e1);
      q_exp2.push_back(e2);
      chk_vld = 1'b1;
      @(negedge clk);
      #1;
      chk_vld = 1'b0;
      step();
   endtask

   task automatic wr(input logic [AW-1:0] idx, input logic [DW-1:0] dat, input logic en);
      bus_if.write_reg  = idx;
      bus_if.write_data = dat;
      bus_if.RegWrite   = en;
      step();
      bus_if.RegWrite   = 1'b0;
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      chk_vld = 1'b0;
      rsta    = 1'b1;
      bus_if.read_reg1  = '0;
      bus_if.read_reg2  = '0;
      bus_if.write_reg  = '0;
      bus_if.write_data = '0;
      bus_if.RegWrite   = 1'b0;

      step();
      expect_rd("reset_held", 5'd1, 5'd31, 32'h0, 32'h0);
      rsta = 1'b0;
      expect_rd("reset_idx0_1", 5'd0, 5'd1, 32'h0, 32'h0);
      expect_rd("reset_idx31", 5'd31, 5'd31, 32'h0, 32'h0);

      wr(5'd1, 32'h0000_00FF, 1'b1);
      expect_rd("wr_x1_port1", 5'd1, 5'd0, 32'h0000_00FF, 32'h0);

      wr(5'd2, 32'h0000_00AA, 1'b1);
      expect_rd("wr_x2_port2", 5'd1, 5'd2, 32'h0000_00FF, 32'h0000_00AA);

      wr(5'd0, 32'hDEAD_BEEF, 1'b1);
      expect_rd("x0_protect", 5'd0, 5'd0, 32'h0, 32'h0);

      wr(5'd3, 32'h1234_5678, 1'b0);
      expect_rd("regwrite_gate", 5'd3, 5'd3, 32'h0, 32'h0);

      wr(5'd31, 32'hFFFF_FFFF, 1'b1);
      expect_rd("wr_x31_both", 5'd31, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // Same-cycle read and write of x5: old value before the edge, new after.
      wr(5'd5, 32'h1111_1111, 1'b1);
      bus_if.write_reg  = 5'd5;
      bus_if.write_data = 32'h2222_2222;
      bus_if.RegWrite   = 1'b1;
      expect_rd("rw_x5_old", 5'd5, 5'd5, 32'h1111_1111, 32'h1111_1111);
      bus_if.RegWrite   = 1'b0;
      expect_rd("rw_x5_new", 5'd5, 5'd1, 32'h2222_2222, 32'h0000_00FF);

      expect_rd("ports_indep", 5'd2, 5'd1, 32'h0000_00AA, 32'h0000_00FF);

      // Async reset between edges, with a write pending that must be ignored.
      rsta = 1'b1;
      bus_if.write_reg  = 5'd4;
      bus_if.write_data = 32'hCAFE_F00D;
      bus_if.RegWrite   = 1'b1;
      expect_rd("async_reset", 5'd1, 5'd31, 32'h0, 32'h0);
      bus_if.RegWrite   = 1'b0;
      rsta = 1'b0;
      expect_rd("wr_in_reset", 5'd4, 5'd2, 32'h0, 32'h0);

      wr(5'd7, 32'hA5A5_A5A5, 1'b1);
      wr(5'd8, 32'h5A5A_5A5A, 1'b1);
      expect_rd("post_reset_wr", 5'd7, 5'd8, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
      expect_rd("post_reset_x5", 5'd5, 5'd0, 32'h0, 32'h0);

      step();
      step();
      tests++;
      if (q_name.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expectations, required 0", q_name.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
